// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus between the MEM stage and data memory.
// master = MEM stage (drives req/we/addr/wdata/be), slave = memory (ack, rdata).
interface mem_stage_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 10
);
  logic                 dmem_req;
  logic                 dmem_we;
  logic [ADDR_SIZE-1:0] dmem_addr;
  logic [WORD_SIZE-1:0] dmem_wdata;
  logic [3:0]           dmem_be;
  logic                 dmem_ack;
  logic [WORD_SIZE-1:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; captures EX results, runs loads/stores on a
// req/ack data-memory bus, aligns/extends load data and strobes write-back.
// Ports: clk, rst_n (async, active low); ex_* capture bundle with
// ex_valid/ex_ready; dmem (mem_stage_if.master) memory bus; mem_fwd_* forward
// value to EX; load_pending for the hazard unit; wb_* write-back strobe/data.
// Option: MISALIGN_TRAP_EN adds a misalign output and suppresses misaligned
// accesses; without it, halfword/word offsets are forced aligned.
module mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_WORDS = 1024,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int ADDR_SIZE = $clog2(NUM_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic [WORD_SIZE-1:0] ex_result,
  input  logic [WORD_SIZE-1:0] ex_write_data,
  input  logic [REG_SEL-1:0]   ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 ex_reg_write,
  input  logic [2:0]           ex_funct3,
  mem_stage_if.master          dmem,
  output logic [WORD_SIZE-1:0] mem_fwd_data,
  output logic [REG_SEL-1:0]   mem_fwd_rd,
  output logic                 mem_fwd_valid,
  output logic                 load_pending,
`ifdef MISALIGN_TRAP_EN
  output logic                 misalign,
`endif
  output logic                 wb_valid,
  output logic                 wb_reg_write,
  output logic [REG_SEL-1:0]   wb_rd,
  output logic [WORD_SIZE-1:0] wb_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [0:0] state;

  logic       accept;
  logic       is_mem;
  logic       issue;
  logic       is_load;
  logic [1:0] a;

  logic                 st_b;
  logic                 st_h;
  logic [1:0]           off;
  logic [3:0]           be_n;
  logic [WORD_SIZE-1:0] wdata_n;

  logic                 cap_load;
  logic                 cap_reg_write;
  logic [2:0]           cap_funct3;
  logic [1:0]           cap_off;

  logic                 ld_b;
  logic                 ld_h;
  logic                 ld_sext;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [WORD_SIZE-1:0] ld_data;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid && ex_ready;
  assign is_mem   = ex_mem_read || ex_mem_write;
  assign is_load  = ex_mem_read && !ex_mem_write;
  assign a        = ex_result[1:0];

`ifdef MISALIGN_TRAP_EN
  logic mis;

  always_comb begin
    mis = 1'b0;
    if (is_mem) begin
      unique case (ex_funct3[1:0])
        2'b01:   mis = a[0];
        2'b10:   mis = (a != 2'b00);
        default: mis = 1'b0;
      endcase
    end
  end

  assign issue = is_mem && !mis;
`else
  assign issue = is_mem;
`endif

  // Byte lanes and replicated store data; the offset is also kept
  // so the load path can pick the same lane when ack returns.
  always_comb begin
    st_b    = (ex_funct3[1:0] == 2'b00);
    st_h    = (ex_funct3[1:0] == 2'b01);
    off     = 2'b00;
    be_n    = 4'b1111;
    wdata_n = ex_write_data;
    unique case (1'b1)
      st_b: begin
        off     = a;
        be_n    = 4'b0001 << a;
        wdata_n = {(WORD_SIZE/8){ex_write_data[7:0]}};
      end
      st_h: begin
        off     = {a[1], 1'b0};
        be_n    = 4'b0011 << {a[1], 1'b0};
        wdata_n = {(WORD_SIZE/16){ex_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = dmem.dmem_rdata[{cap_off, 3'b000} +: 8];
  assign ld_half = dmem.dmem_rdata[{cap_off[1], 4'b0000} +: 16];
  assign ld_sext = !cap_funct3[2];

  always_comb begin
    ld_b    = (cap_funct3[1:0] == 2'b00);
    ld_h    = (cap_funct3[1:0] == 2'b01);
    ld_data = dmem.dmem_rdata;
    unique case (1'b1)
      ld_b: ld_data = {{(WORD_SIZE-8){ld_sext & ld_byte[7]}},
                       ld_byte};
      ld_h: ld_data = {{(WORD_SIZE-16){ld_sext & ld_half[15]}},
                       ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      dmem.dmem_be    <= '0;
      cap_load        <= 1'b0;
      cap_reg_write   <= 1'b0;
      cap_funct3      <= '0;
      cap_off         <= '0;
      mem_fwd_data    <= '0;
      mem_fwd_rd      <= '0;
      mem_fwd_valid   <= 1'b0;
      load_pending    <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign        <= 1'b0;
`endif
      wb_valid        <= 1'b0;
      wb_reg_write    <= 1'b0;
      wb_rd           <= '0;
      wb_data         <= '0;
    end else begin
      wb_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      if (state == IDLE) begin
        if (accept) begin
          cap_load      <= is_load;
          cap_reg_write <= ex_reg_write;
          cap_funct3    <= ex_funct3;
          cap_off       <= off;
          mem_fwd_data  <= ex_result;
          mem_fwd_rd    <= ex_rd;
          mem_fwd_valid <= ex_reg_write && !ex_mem_read;
          if (issue) begin
            state           <= REQ;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= ex_mem_write;
            dmem.dmem_addr  <= ex_result[ADDR_SIZE+1:2];
            dmem.dmem_wdata <= wdata_n;
            dmem.dmem_be    <= be_n;
            load_pending    <= is_load;
          end else begin
            // ALU op, or a trapped access: retire next cycle
            // without touching memory or the register file.
            wb_valid     <= 1'b1;
            wb_reg_write <= ex_reg_write && !is_mem;
            wb_rd        <= ex_rd;
            wb_data      <= ex_result;
`ifdef MISALIGN_TRAP_EN
            misalign     <= mis;
`endif
          end
        end else begin
          mem_fwd_valid <= 1'b0;
        end
      end else begin
        if (dmem.dmem_ack) begin
          state         <= IDLE;
          dmem.dmem_req <= 1'b0;
          load_pending  <= 1'b0;
          wb_valid      <= 1'b1;
          wb_reg_write  <= cap_reg_write && cap_load;
          wb_rd         <= mem_fwd_rd;
          wb_data       <= cap_load ? ld_data : mem_fwd_data;
        end
      end
    end
  end

endmodule
